// File: rtl/countdown_timer_ctrl.sv
// rtl/countdown_timer_ctrl.sv - countdown timer with internal tick prescaler and alarm sequencing
module countdown_timer_ctrl #(
  parameter int TICK_DIV    = 10_000_000,
  parameter int CNT_W       = 12,
  parameter int ALARM_TICKS = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             start_i,
  input  logic             pause_i,
  input  logic             clear_i,
  output logic [CNT_W-1:0] remaining_o,
  output logic [2:0]       state_o,
  output logic             tick_o,
  output logic             expired_o,
  output logic             alarm_o
);

  localparam int PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int ACNT_W = $clog2(ALARM_TICKS + 1);
  localparam logic [PRE_W-1:0]  PRE_LAST   = PRE_W'(TICK_DIV - 1);
  localparam logic [ACNT_W-1:0] ALARM_LAST = ACNT_W'(ALARM_TICKS - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOADED  = 3'd1,
    RUNNING = 3'd2,
    PAUSED  = 3'd3,
    EXPIRED = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    rem_q, rem_d;
  logic [PRE_W-1:0]    pre_q, pre_d;
  logic [ACNT_W-1:0]   acnt_q, acnt_d;
  logic                tick_q, tick_d;
  logic                alarm_q, alarm_d;
  logic                expired_q, expired_d;
  logic                wrap;
  logic                cmd_start;

  assign wrap      = (pre_q == PRE_LAST);
  // start acts only when no higher-priority command is present
  assign cmd_start = start_i && !pause_i;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    pre_d   = pre_q;
    acnt_d  = acnt_q;
    tick_d  = 1'b0;
    alarm_d = alarm_q;
    if (clear_i) begin
      state_d = IDLE;
      rem_d   = '0;
      pre_d   = '0;
      acnt_d  = '0;
      alarm_d = 1'b0;
    end else if (load_i) begin
      state_d = (load_val_i != '0) ? LOADED : IDLE;
      rem_d   = load_val_i;
      pre_d   = '0;
      acnt_d  = '0;
      alarm_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: pre_d = '0;
        LOADED: begin
          pre_d = '0;
          if (cmd_start) state_d = RUNNING;
        end
        RUNNING: begin
          pre_d  = wrap ? '0 : pre_q + PRE_W'(1);
          tick_d = wrap;
          if (wrap) rem_d = rem_q - CNT_W'(1);
          // a final tick wins over a coincident pause
          if (wrap && rem_q == CNT_W'(1)) begin
            state_d = EXPIRED;
            alarm_d = 1'b1;
            acnt_d  = '0;
          end else if (pause_i) begin
            state_d = PAUSED;
          end
        end
        PAUSED: begin
          if (cmd_start) state_d = RUNNING;
        end
        EXPIRED: begin
          pre_d  = wrap ? '0 : pre_q + PRE_W'(1);
          tick_d = wrap;
          if (wrap && alarm_q) begin
            acnt_d = acnt_q + ACNT_W'(1);
            if (acnt_q == ALARM_LAST) alarm_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign expired_d = (state_d == EXPIRED);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      pre_q     <= '0;
      acnt_q    <= '0;
      tick_q    <= 1'b0;
      alarm_q   <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      pre_q     <= pre_d;
      acnt_q    <= acnt_d;
      tick_q    <= tick_d;
      alarm_q   <= alarm_d;
      expired_q <= expired_d;
    end
  end

  assign remaining_o = rem_q;
  assign state_o     = state_q;
  assign tick_o      = tick_q;
  assign expired_o   = expired_q;
  assign alarm_o     = alarm_q;

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// tb/tb_countdown_timer_ctrl.sv - randomized and directed bench for countdown_timer_ctrl
module tb_countdown_timer_ctrl;
  localparam int TD = 10;
  localparam int CW = 12;
  localparam int AT = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          load = 1'b0, start = 1'b0, pause = 1'b0, clear = 1'b0;
  logic [CW-1:0] load_val = '0;
  logic [CW-1:0] remaining_o;
  logic [2:0]    state_o;
  logic          tick_o, expired_o, alarm_o;

  countdown_timer_ctrl #(.TICK_DIV(TD), .CNT_W(CW), .ALARM_TICKS(AT)) dut (
    .clk(clk), .reset(reset), .load_i(load), .load_val_i(load_val),
    .start_i(start), .pause_i(pause), .clear_i(clear),
    .remaining_o(remaining_o), .state_o(state_o), .tick_o(tick_o),
    .expired_o(expired_o), .alarm_o(alarm_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model in terms of elapsed time: total counted cycles since
  // start and cycles spent expired, with remaining derived by division.
  int m_state, m_load, m_run, m_exp;
  bit m_tick;

  logic [CW+5:0] dut_vec;
  assign dut_vec = {state_o, remaining_o, tick_o, expired_o, alarm_o};

  function automatic void model_reset();
    m_state = 0; m_load = 0; m_run = 0; m_exp = 0; m_tick = 0;
  endfunction

  function automatic void model_edge(bit c, bit l, bit s, bit p, int v);
    m_tick = 0;
    if (c) begin
      m_state = 0; m_load = 0; m_run = 0;
    end else if (l) begin
      m_load = v; m_run = 0;
      m_state = (v != 0) ? 1 : 0;
    end else begin
      case (m_state)
        1: if (s && !p) begin m_state = 2; m_run = 0; end
        2: begin
          m_run++;
          if (m_run % TD == 0) m_tick = 1;
          if (m_load - m_run / TD == 0) begin m_state = 4; m_exp = 0; end
          else if (p) m_state = 3;
        end
        3: if (s && !p) m_state = 2;
        4: begin
          m_run++; m_exp++;
          if (m_run % TD == 0) m_tick = 1;
        end
        default: ;
      endcase
    end
  endfunction

  function automatic logic [CW+5:0] m_vec();
    int  rem;
    bit  alm;
    rem = (m_state == 0 || m_state == 4) ? 0 : m_load - m_run / TD;
    alm = (m_state == 4) && (m_exp < AT * TD);
    return {3'(m_state), CW'(rem), m_tick, (m_state == 4), alm};
  endfunction

  // Called at a negedge; returns at the following negedge.
  task automatic step(input bit l, input bit s, input bit p, input bit c, input int v);
    load = l; start = s; pause = p; clear = c; load_val = CW'(v);
    @(posedge clk);
    model_edge(c, l, s, p, v);
    @(negedge clk);
    load = 0; start = 0; pause = 0; clear = 0; load_val = '0;
  endtask

  task automatic test_reset();
    model_reset();
    checks++;
    if (dut_vec !== '0) begin
      errors++; $display("FAIL reset_state dut=%h want=0", dut_vec);
    end
  endtask

  task automatic test_basic_countdown();
    step(0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 3);
    step(0, 1, 0, 0, 0);
    for (int k = 1; k <= 70; k++) begin
      step(0, 0, 0, 0, 0);
      checks++;
      if (dut_vec !== m_vec()) begin
        errors++; $display("FAIL basic_model k=%0d dut=%h want=%h", k, dut_vec, m_vec());
      end
      if (k == 10 || k == 20 || k == 30) begin
        checks++;
        if (remaining_o !== CW'(3 - k / 10) || tick_o !== 1'b1) begin
          errors++; $display("FAIL basic_dec k=%0d rem=%0d tick=%b want rem=%0d tick=1", k, remaining_o, tick_o, 3 - k / 10);
        end
      end
      if (k == 30 || k == 59 || k == 60) begin
        checks++;
        if (state_o !== 3'd4 || alarm_o !== (k != 60)) begin
          errors++; $display("FAIL basic_alarm k=%0d state=%0d alarm=%b want state=4 alarm=%b", k, state_o, alarm_o, k != 60);
        end
      end
    end
  endtask

  task automatic test_pause_resume();
    step(0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 5);
    step(0, 1, 0, 0, 0);
    for (int k = 1; k <= 130; k++) begin
      step(0, k == 100, k == 14, 0, 0);
      checks++;
      if (dut_vec !== m_vec()) begin
        errors++; $display("FAIL pause_model k=%0d dut=%h want=%h", k, dut_vec, m_vec());
      end
      if (k == 14 || k == 99 || k == 105) begin
        checks++;
        if (remaining_o !== CW'(4)) begin
          errors++; $display("FAIL pause_hold k=%0d rem=%0d want=4", k, remaining_o);
        end
      end
      if (k == 106 || k == 116) begin
        checks++;
        if (remaining_o !== CW'(3 - (k - 106) / 10) || tick_o !== 1'b1) begin
          errors++; $display("FAIL resume_dec k=%0d rem=%0d tick=%b", k, remaining_o, tick_o);
        end
      end
    end
  endtask

  task automatic test_pause_final_tick();
    step(0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0);
    for (int k = 1; k <= 10; k++) step(0, 0, k == 10, 0, 0);
    checks++;
    if (state_o !== 3'd4 || remaining_o !== '0 || alarm_o !== 1'b1 || dut_vec !== m_vec()) begin
      errors++; $display("FAIL pause_final state=%0d rem=%0d alarm=%b want 4/0/1", state_o, remaining_o, alarm_o);
    end
  endtask

  task automatic test_priority();
    step(1, 0, 0, 0, 9);
    step(0, 1, 0, 0, 0);
    for (int k = 0; k < 13; k++) step(0, 0, 0, 0, 0);
    step(1, 1, 0, 1, 7);
    checks++;
    if (state_o !== 3'd0 || remaining_o !== '0 || dut_vec !== m_vec()) begin
      errors++; $display("FAIL prio_clear state=%0d rem=%0d want 0/0", state_o, remaining_o);
    end
    step(1, 1, 0, 0, 6);
    step(0, 0, 0, 0, 0);
    checks++;
    if (state_o !== 3'd1 || remaining_o !== CW'(6) || dut_vec !== m_vec()) begin
      errors++; $display("FAIL prio_load state=%0d rem=%0d want 1/6", state_o, remaining_o);
    end
  endtask

  task automatic test_ignored();
    step(0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    checks++;
    if (state_o !== 3'd0 || tick_o !== 1'b0 || dut_vec !== m_vec()) begin
      errors++; $display("FAIL idle_ignore state=%0d tick=%b want 0/0", state_o, tick_o);
    end
    step(1, 0, 0, 0, 4);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    checks++;
    if (state_o !== 3'd1 || remaining_o !== CW'(4) || tick_o !== 1'b0) begin
      errors++; $display("FAIL loaded_pause state=%0d rem=%0d want 1/4", state_o, remaining_o);
    end
    step(1, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0);
    for (int k = 0; k < 10; k++) step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    checks++;
    if (state_o !== 3'd4 || expired_o !== 1'b1 || dut_vec !== m_vec()) begin
      errors++; $display("FAIL expired_start state=%0d expired=%b want 4/1", state_o, expired_o);
    end
  endtask

  task automatic test_async_reset();
    step(0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 9);
    step(0, 1, 0, 0, 0);
    for (int k = 0; k < 26; k++) step(0, 0, 0, 0, 0);
    checks++;
    if (remaining_o !== CW'(7) || state_o !== 3'd2) begin
      errors++; $display("FAIL pre_reset rem=%0d state=%0d want 7/2", remaining_o, state_o);
    end
    #2 reset = 1'b0;
    #1;
    model_reset();
    checks++;
    if (dut_vec !== '0) begin
      errors++; $display("FAIL async_reset dut=%h want=0", dut_vec);
    end
    @(negedge clk);
    reset = 1'b1;
    step(1, 0, 0, 0, 2);
    step(0, 1, 0, 0, 0);
    for (int k = 1; k <= 20; k++) begin
      step(0, 0, 0, 0, 0);
      checks++;
      if (dut_vec !== m_vec() || (state_o == 3'd4) !== (k == 20)) begin
        errors++; $display("FAIL reload_expiry k=%0d dut=%h want=%h", k, dut_vec, m_vec());
      end
    end
  endtask

  task automatic test_random();
    bit c, l, s, p;
    int v;
    step(0, 0, 0, 1, 0);
    for (int k = 0; k < 1500; k++) begin
      c = ($urandom_range(0, 79) == 0);
      l = ($urandom_range(0, 24) == 0);
      s = ($urandom_range(0, 5) == 0);
      p = ($urandom_range(0, 11) == 0);
      v = $urandom_range(0, 5);
      step(l, s, p, c, v);
      checks++;
      if (dut_vec !== m_vec()) begin
        errors++; $display("FAIL random k=%0d cmd=%b%b%b%b v=%0d dut=%h want=%h", k, c, l, p, s, v, dut_vec, m_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    test_reset();
    reset = 1'b1;
    @(negedge clk);
    test_basic_countdown();
    test_pause_resume();
    test_pause_final_tick();
    test_priority();
    test_ignored();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
